// File: rtl/ifm_prefetch.sv
// Prefetching instruction fetch unit: pipelined Wishbone B4 reads with bounded
// outstanding requests, a PC-tagged prefetch FIFO and redirect/flush handling.
`timescale 1ns/1ps
module ifm_prefetch #(
  parameter int unsigned DEPTH             = 4,
  parameter int unsigned MAX_OUTSTANDING   = 2,
  parameter logic [31:0] BOOT_ADDRESS      = 32'h0000_0000,
  parameter logic [31:0] INTERRUPT_ADDRESS = 32'h0000_1000,
  parameter logic [31:0] DEBUG_ADDRESS     = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_i,
  input  logic        drq_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        wb_cyc_o,
  input  logic        wb_stall_i,
  input  logic        output_ready_i,
  output logic        output_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned QW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW   = 6;

  logic [31:0]     r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [31:0]     r_fifo_pc    [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CNTW-1:0] r_count;
  logic [31:0]     r_aq [MAX_OUTSTANDING];
  logic [QW-1:0]   r_aq_rd;
  logic [QW-1:0]   r_aq_wr;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic [CW-1:0] w_in_flight;
  logic [CW-1:0] w_fifo_used;
  logic          w_issue_ok;
  logic          w_accept;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  function automatic logic [QW-1:0] aq_next(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  always_comb begin
    w_redirect = drq_i | irq_i | branch_i;
    if (drq_i)      w_target = DEBUG_ADDRESS;
    else if (irq_i) w_target = INTERRUPT_ADDRESS;
    else            w_target = branch_target_i & 32'hFFFF_FFFC;
    // Stale requests hold a bus slot but no FIFO slot.
    w_in_flight = r_outstanding + r_discard;
    w_fifo_used = CW'(r_count) + r_outstanding;
    // rst_i gates the strobe so the bus goes idle the instant reset asserts.
    w_issue_ok  = rst_i & ~w_redirect
                & (w_in_flight < CW'(MAX_OUTSTANDING))
                & (w_fifo_used < CW'(DEPTH));
    w_accept    = w_issue_ok & ~wb_stall_i;
    w_drop      = wb_ack_i & (r_discard != '0);
    w_push      = wb_ack_i & (r_discard == '0);
    w_pop       = (r_count != '0) & output_ready_i;
  end

  assign wb_stb_o       = w_issue_ok;
  assign wb_adr_o       = w_issue_ok ? r_pc : '0;
  assign wb_cyc_o       = w_issue_ok | (w_in_flight != '0);
  assign output_valid_o = (r_count != '0);
  assign instr_o        = r_fifo_instr[r_rd_ptr];
  assign pc_o           = r_fifo_pc[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc          <= BOOT_ADDRESS;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_aq_rd       <= '0;
      r_aq_wr       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fifo_instr[i] <= '0;
        r_fifo_pc[i]    <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_aq[i] <= '0;
    end else if (w_redirect) begin
      // Every live request becomes stale; an ack landing now is already dropped.
      r_pc          <= w_target;
      r_discard     <= w_in_flight - CW'(wb_ack_i);
      r_outstanding <= '0;
      r_aq_rd       <= '0;
      r_aq_wr       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else begin
      if (w_accept) begin
        r_pc          <= r_pc + 32'd4;
        r_aq[r_aq_wr] <= r_pc;
        r_aq_wr       <= aq_next(r_aq_wr);
      end
      if (w_drop) r_discard <= r_discard - CW'(1);
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= wb_dat_i;
        r_fifo_pc[r_wr_ptr]    <= r_aq[r_aq_rd];
        r_wr_ptr               <= r_wr_ptr + PW'(1);
        r_aq_rd                <= aq_next(r_aq_rd);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_push);
      r_count       <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

endmodule

// File: tb/tb_ifm_prefetch.sv
// Bench for ifm_prefetch: zero-wait pipelined slave model, fetch-order
// scoreboard, redirect vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ifm_prefetch;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] INTA = 32'h0000_1000;
  localparam logic [31:0] DBGA = 32'h0000_2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, irq_i, drq_i, branch_i;
  logic [31:0] branch_target_i;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        wb_stb_o, wb_ack_i, wb_cyc_o, wb_stall_i;
  logic        output_ready_i, output_valid_o;
  logic [31:0] instr_o, pc_o;

  ifm_prefetch #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .BOOT_ADDRESS(BOOT),
    .INTERRUPT_ADDRESS(INTA), .DEBUG_ADDRESS(DBGA)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .irq_i(irq_i), .drq_i(drq_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i), .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
    .output_ready_i(output_ready_i), .output_valid_o(output_valid_o),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct {
    logic drq; logic irq; logic br; logic [31:0] target; logic [31:0] exp_adr;
  } redir_vec_t;

  exp_t        sb[$];
  logic [31:0] sq[$];
  int n_pass = 0, n_total = 0, n_acc = 0, max_inflight = 0;
  logic stall_v = 1'b0, ready_v = 1'b0, ack_en = 1'b0;
  logic p_drq = 1'b0, p_irq = 1'b0, p_br = 1'b0;
  logic [31:0] p_target = '0;
  logic [31:0] model_pc = BOOT;
  logic s_stb, s_cyc, s_valid;
  logic [31:0] s_adr, s_instr, s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    exp_t e;
    logic redir;
    @(negedge clk);
    if (ack_en && sq.size() > 0) begin
      wb_ack_i = 1'b1; wb_dat_i = mem_word(sq[0]);
    end else begin
      wb_ack_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
    end
    wb_stall_i = stall_v; output_ready_i = ready_v;
    drq_i = p_drq; irq_i = p_irq; branch_i = p_br; branch_target_i = p_target;
    redir = p_drq | p_irq | p_br;
    p_drq = 1'b0; p_irq = 1'b0; p_br = 1'b0;
    #1;
    s_stb = wb_stb_o; s_cyc = wb_cyc_o; s_adr = wb_adr_o;
    s_valid = output_valid_o; s_instr = instr_o; s_pc = pc_o;
    if (s_valid && output_ready_i && !redir) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got pc %h, expected no output", s_pc);
      end else begin
        e = sb.pop_front();
        check("out_pc", s_pc, e.pc);
        check("out_instr", s_instr, e.instr);
      end
    end
    if (s_stb && !wb_stall_i) begin
      check("req_adr", s_adr, model_pc);
      sb.push_back('{model_pc, mem_word(model_pc)});
      sq.push_back(s_adr);
      model_pc += 32'd4;
      n_acc++;
    end
    if (wb_ack_i) void'(sq.pop_front());
    if (sq.size() > max_inflight) max_inflight = sq.size();
    if (redir) begin
      sb.delete();
      if (drq_i)      model_pc = DBGA;
      else if (irq_i) model_pc = INTA;
      else            model_pc = {branch_target_i[31:2], 2'b00};
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    redir_vec_t vecs[7];
    int first_valid;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0100};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0000_0104, INTA};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0108, DBGA};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_010C, DBGA};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0110, INTA};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_033B, 32'h0000_0338};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};

    rst_i = 1'b0; irq_i = 1'b0; drq_i = 1'b0; branch_i = 1'b0;
    branch_target_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0;
    wb_stall_i = 1'b0; output_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_valid", output_valid_o, 1'b0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    @(posedge clk); #1 rst_i = 1'b1;

    // Streaming with a zero-wait slave and an always-ready decoder
    ready_v = 1'b1; ack_en = 1'b1; n_acc = 0; max_inflight = 0; first_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (i == 1) begin
        check("first_stb", s_stb, 1'b1);
        check("first_adr", s_adr, BOOT);
      end
      if (s_valid && first_valid == 0) first_valid = i;
    end
    check("burst_accepts", n_acc, 20);
    check("first_valid_cycle", first_valid, 3);
    check("max_outstanding", max_inflight <= 2, 1'b1);

    // Backpressure: FIFO fills, then one pop buys one request
    ready_v = 1'b0; p_br = 1'b1; p_target = 32'h400; cyc();
    n_acc = 0;
    repeat (10) cyc();
    check("bp_accepts", n_acc, 4);
    check("bp_stb_idle", s_stb, 1'b0);
    check("bp_valid", s_valid, 1'b1);
    check("bp_head_pc", s_pc, 32'h400);
    check("bp_head_instr", s_instr, mem_word(32'h400));
    n_acc = 0;
    ready_v = 1'b1; cyc(); ready_v = 1'b0;
    repeat (6) cyc();
    check("bp_one_more", n_acc, 1);

    // Redirect table: precedence, alignment and PC wrap
    for (int v = 0; v < 7; v++) begin
      p_drq = vecs[v].drq; p_irq = vecs[v].irq; p_br = vecs[v].br;
      p_target = vecs[v].target;
      cyc();
      check("redir_stb_low", s_stb, 1'b0);
      ready_v = 1'b1;
      cyc();
      check("redir_stb", s_stb, 1'b1);
      check("redir_adr", s_adr, vecs[v].exp_adr);
      check("redir_valid_low", s_valid, 1'b0);
      repeat (6) cyc();
    end

    // Stall holds address and strobe
    p_br = 1'b1; p_target = 32'h8; cyc();
    stall_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_stb", s_stb, 1'b1);
      check("stall_adr", s_adr, 32'h8);
    end
    stall_v = 1'b0;
    cyc(); check("stall_release_adr", s_adr, 32'h8);
    cyc(); check("stall_next_adr", s_adr, 32'hC);
    repeat (4) cyc();

    // Branch with two requests in flight: both acks must be dropped
    p_br = 1'b1; p_target = 32'h40; cyc();
    ack_en = 1'b0;
    cyc(); cyc();
    cyc(); check("max_out_stb_low", s_stb, 1'b0);
    p_br = 1'b1; p_target = 32'h100; cyc();
    check("br_cyc_high", s_cyc, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("drain_stb_low", s_stb, 1'b0);
      check("drain_cyc_high", s_cyc, 1'b1);
      check("drain_valid_low", s_valid, 1'b0);
    end
    ack_en = 1'b1; first_valid = 0;
    for (int i = 1; i <= 10 && first_valid == 0; i++) begin
      cyc();
      if (s_valid) begin
        first_valid = i;
        check("br_first_pc", s_pc, 32'h100);
      end
    end
    check("br_output_seen", first_valid != 0, 1'b1);
    repeat (6) cyc();

    // Asynchronous reset mid-burst
    ack_en = 1'b0;
    repeat (3) cyc();
    @(negedge clk); #2 rst_i = 1'b0; #1;
    check("async_stb", wb_stb_o, 1'b0);
    check("async_cyc", wb_cyc_o, 1'b0);
    check("async_adr", wb_adr_o, 32'h0);
    check("async_valid", output_valid_o, 1'b0);
    check("async_instr", instr_o, 32'h0);
    check("async_pc", pc_o, 32'h0);
    sq.delete(); sb.delete(); model_pc = BOOT; ack_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;
    cyc();
    check("restart_stb", s_stb, 1'b1);
    check("restart_adr", s_adr, BOOT);
    repeat (8) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
